// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: receives a length-prefixed, XOR-checksummed frame,
// writes 32-bit words into IMEM, and releases the core only after a clean checksum.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a byte moves only on a rising edge where in_valid && in_ready; in_ready
  // depends on state alone, so the sender may hold in_valid high indefinitely.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q;
  logic [1:0]          byte_idx_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [23:0]         shift_q;
  logic [7:0]          csum_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;

  logic        xfer;
  logic        idle_like;
  logic [15:0] len_full;
  logic        last_byte;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign len_full  = {len_q[15:8], in_data};
  assign last_byte = (byte_idx_q == 2'd3);
  assign last_word = (17'(word_idx_q) == (17'(len_q) - 17'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)             state_d = S_CHK;
          else if (17'(len_full) > MAX_N)    state_d = S_ERR;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: if (xfer && last_byte && last_word) state_d = S_CHK;
      S_CHK: begin
        if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    cpu_run     = 1'b0;
    dbg_state_o = state_q;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: in_ready = 1'b1;
      S_DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the write strobe is a one-cycle pulse registered off the 4th byte, so a reset
  // before that edge discards the partial word held in shift_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      wen_q <= 1'b0;
      if (idle_like && start) begin
        len_q      <= '0;
        byte_idx_q <= '0;
        word_idx_q <= '0;
        shift_q    <= '0;
        csum_q     <= '0;
      end else if (xfer) begin
        case (state_q)
          S_LEN_HI: begin
            len_q[15:8] <= in_data;
            csum_q      <= csum_q ^ in_data;
          end
          S_LEN_LO: begin
            len_q[7:0] <= in_data;
            csum_q     <= csum_q ^ in_data;
          end
          S_DATA: begin
            csum_q     <= csum_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (last_byte) begin
              wen_q      <= 1'b1;
              addr_q     <= word_idx_q;
              wdata_q    <= {shift_q, in_data};
              word_idx_q <= word_idx_q + 1'b1;
            end else begin
              shift_q <= {shift_q[15:0], in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_wen   = wen_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset, 1 = run).
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 in_valid  input  1  byte stream valid.
REQ-006 in_data  input  8  byte stream data.
REQ-007 in_ready  output  1  loader accepts byte this cycle; transfer = in_valid && in_ready.
REQ-008 imem_wen  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of write.
REQ-010 imem_wdata  output  32  word written.
REQ-011 cpu_run  output  1  1 = core may fetch/execute loaded program; 0 = core held off.
REQ-012 done  output  1  level, session ended with good checksum.
REQ-013 err  output  1  level, session ended with length or checksum error.

Function
REQ-014 Frame format, in order: LEN_HI, LEN_LO (16-bit word count N, big-endian), 4*N data bytes, one checksum byte.
REQ-015 FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
REQ-016 IDLE/DONE/ERR: start -> LEN_HI; clear byte index, word address, running checksum; done, err, cpu_run go 0 on that edge.
REQ-017 start in LEN_HI/LEN_LO/DATA/CHK is ignored.
REQ-018 in_ready = 1 exactly in LEN_HI, LEN_LO, DATA, CHK; 0 elsewhere; combinational from state only.
REQ-019 No transfer (in_valid = 0) -> state and counters hold; no timeout.
REQ-020 Running checksum = XOR of every accepted byte from LEN_HI through last data byte; checksum byte excluded.
REQ-021 LEN_LO transfer: N = 0 -> CHK; N > 2^ADDR_W -> ERR; otherwise -> DATA.
REQ-022 DATA: bytes packed big-endian: 1st byte -> [31:24], 4th -> [7:0].
REQ-023 On 4th byte transfer: next cycle imem_wen = 1 for exactly one cycle, imem_addr = word index (first word 0), imem_wdata = packed word.
REQ-024 Word index increments after each write; after word N-1 completes assembly -> CHK.
REQ-025 Back-to-back bytes at full rate SHALL produce no lost writes; imem_wen never asserted outside DATA-driven writes.
REQ-026 CHK transfer: byte == running checksum -> DONE, else -> ERR.
REQ-027 DONE: done = 1, cpu_run = 1, err = 0. ERR: err = 1, done = 0, cpu_run = 0.
REQ-028 imem_addr/imem_wdata hold last written value when imem_wen = 0.
REQ-029 Words already written before ERR are not rolled back.

Reset
REQ-030 rst = 0 at any time, including mid-DATA: state -> IDLE immediately; in_ready, imem_wen, done, err, cpu_run = 0; imem_addr, imem_wdata, counters, checksum = 0.
REQ-031 A partially assembled word at reset SHALL never be written.
REQ-032 After rst release, loader stays IDLE with cpu_run = 0 until a start and a good frame.

Verification
REQ-033 start; bytes 00 01 24 08 00 05 28 -> one imem_wen, addr 0, data 0x24080005; then done = 1, cpu_run = 1, err = 0.
REQ-034 start; bytes 00 00 00 -> no imem_wen; done = 1, cpu_run = 1.
REQ-035 start; bytes 00 01 24 08 00 05 29 -> write at addr 0 occurs; err = 1, done = 0, cpu_run = 0.
REQ-036 ADDR_W = 10; start; bytes 04 01 -> ERR immediately after LEN_LO, in_ready = 0, no writes.
REQ-037 start; N = 2 with in_valid toggling every other cycle -> writes addr 0 then 1, correct data, done; then rst = 0 during second session's DATA -> all outputs 0, no write of partial word.
